// File: rtl/apb_i2c_pkg.sv
// apb_i2c_pkg: bridge register map, control codes and sequencer enums.
package apb_i2c_pkg;
    localparam int unsigned REG_CTRL   = 2;
    localparam int unsigned REG_TXDATA = 4;
    localparam int unsigned REG_ADDR   = 6;
    localparam logic [7:0] CTRL_RESET  = 8'hF6;
    localparam logic [7:0] CTRL_ENABLE = 8'hFC;
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_GAP} state_e;
    typedef enum logic [1:0] {STEP_CTRL_RST, STEP_ADDR, STEP_DATA, STEP_CTRL_EN} step_e;
endpackage

// File: rtl/apb_seq_fifo.sv
// apb_seq_fifo: payload byte FIFO with occupancy count and synchronous flush.
module apb_seq_fifo #(
    parameter int DATAWIDTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            push_i,
    input  logic                            pop_i,
    input  logic                            flush_i,
    input  logic [DATAWIDTH-1:0]            data_i,
    output logic [DATAWIDTH-1:0]            data_o,
    output logic [$clog2(FIFO_DEPTH):0]     count_o,
    output logic                            full_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic do_push, do_pop;
    assign full_o  = count_q == (AW+1)'(FIFO_DEPTH);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && count_q != '0 && !flush_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            count_q  <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/apb_i2c_cmd_sequencer.sv
// apb_i2c_cmd_sequencer: buffers payload bytes and replays them to the I2C bridge
// as the APB write sequence ctrl-reset, slave address, data bytes, ctrl-enable.
module apb_i2c_cmd_sequencer
    import apb_i2c_pkg::*;
#(
    parameter int ADDRESSWIDTH  = 4,
    parameter int DATAWIDTH     = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int READY_TIMEOUT = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    wr_valid,
    input  logic [DATAWIDTH-1:0]    wr_data,
    output logic                    wr_ready,
    input  logic                    start,
    input  logic [DATAWIDTH-1:0]    slave_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDRESSWIDTH-1:0] PADDR,
    output logic [DATAWIDTH-1:0]    PWDATA,
    output logic                    PWRITE,
    output logic                    PSELx,
    output logic                    PENABLE,
    input  logic                    PREADY
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(READY_TIMEOUT + 1);
    state_e state_q, state_d;
    step_e step_q, step_d;
    logic [CW-1:0] n_q, n_d, fifo_count;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [DATAWIDTH-1:0] addr_q, addr_d, pwdata_q, pwdata_d, fifo_head;
    logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, alive_q;
    logic fifo_full, pop, flush;
    apb_seq_fifo #(.DATAWIDTH(DATAWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i(PCLK), .rst_i(PRESET), .push_i(wr_valid && wr_ready), .pop_i(pop),
        .flush_i(flush), .data_i(wr_data), .data_o(fifo_head), .count_o(fifo_count),
        .full_o(fifo_full)
    );
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        n_d      = n_q;
        tmr_d    = tmr_q;
        addr_d   = addr_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_SETUP;
                step_d   = STEP_CTRL_RST;
                busy_d   = 1'b1;
                addr_d   = slave_addr;
                n_d      = fifo_count;
                paddr_d  = ADDRESSWIDTH'(REG_CTRL);
                pwdata_d = DATAWIDTH'(CTRL_RESET);
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                tmr_d   = '0;
            end
            S_ACCESS: if (PREADY) begin
                state_d = S_GAP;
                pop     = step_q == STEP_DATA;
                n_d     = step_q == STEP_DATA ? n_q - CW'(1) : n_q;
            end else if (tmr_q == TW'(READY_TIMEOUT - 1)) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b1;
                flush   = 1'b1;
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
            S_GAP: if (step_q == STEP_CTRL_EN) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                // fifo_head already shows the next byte: the pop landed at the end of ACCESS
                state_d  = S_SETUP;
                step_d   = step_q == STEP_CTRL_RST ? STEP_ADDR : n_q != '0 ? STEP_DATA : STEP_CTRL_EN;
                paddr_d  = step_d == STEP_ADDR ? ADDRESSWIDTH'(REG_ADDR) :
                           step_d == STEP_DATA ? ADDRESSWIDTH'(REG_TXDATA) : ADDRESSWIDTH'(REG_CTRL);
                pwdata_d = step_d == STEP_ADDR ? addr_q :
                           step_d == STEP_DATA ? fifo_head : DATAWIDTH'(CTRL_ENABLE);
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            step_q   <= STEP_CTRL_RST;
            n_q      <= '0;
            tmr_q    <= '0;
            addr_q   <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            alive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            n_q      <= n_d;
            tmr_q    <= tmr_d;
            addr_q   <= addr_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            alive_q  <= 1'b1;
        end
    end
    assign wr_ready = alive_q && !fifo_full && !busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign PWRITE   = state_q != S_IDLE;
    assign PSELx    = state_q == S_SETUP || state_q == S_ACCESS;
    assign PENABLE  = state_q == S_ACCESS;
endmodule
